// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   Runtime-programmable clock divider / phase generator.
//
//   Channel 0 is the base divided clock. Channel i is the base clock delayed by
//   i master cycles. Each channel can be inverted with a fixed mask bit.
//   Divide-ratio changes take effect only at a period boundary, so every period
//   that has started runs to completion at its old ratio.
//
// Ports
//   clock        in   1        master clock, all state updates on its rising edge
//   reset        in   1        synchronous active-high reset
//   run          in   1        1 = advance, 0 = freeze all state and outputs
//   div_load     in   1        capture div_ratio_in as the pending ratio
//   div_ratio_in in   CNT_W    requested divide ratio (0 and 1 are raised to 2)
//   clk_out      out  NUM_CH   registered divided clocks
//   tick         out  1        pulse in the first high cycle of base clk_out[0]
//   div_active   out  CNT_W    ratio currently in effect
//   load_pending out  1        a captured ratio awaits the next period boundary
//   load_ack     out  1        pulse in the cycle after a pending ratio is applied
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int                NUM_CH      = 4,
    parameter int                CNT_W       = 8,
    parameter int                DEFAULT_DIV = 4,
    parameter logic [NUM_CH-1:0] INV_MASK    = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              div_load,
    input  logic [CNT_W-1:0]  div_ratio_in,
    output logic [NUM_CH-1:0] clk_out,
    output logic              tick,
    output logic [CNT_W-1:0]  div_active,
    output logic              load_pending,
    output logic              load_ack
);

    // Ratios below 2 cannot produce a clock with both a low and a high phase.
    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] r);
        return (r < CNT_W'(2)) ? CNT_W'(2) : r;
    endfunction

    logic [CNT_W-1:0]  cnt_p0;
    logic [CNT_W-1:0]  div_q;
    logic [CNT_W-1:0]  pending_q;
    logic              pending_vld_q;
    logic              tick_q;
    logic              ack_q;
    logic [NUM_CH-1:0] chan_p1;

    logic [CNT_W-1:0]  half;
    logic              at_end;
    logic              apply;

    always_comb begin
        half   = div_q >> 1;
        at_end = (cnt_p0 == div_q - CNT_W'(1));
        // pending_vld_q is registered, so a ratio captured in this very cycle
        // cannot be applied here; it waits for the following boundary.
        apply  = run & pending_vld_q & at_end;
    end

    // Stage p0: period counter, active ratio and pending-ratio bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_p0        <= '0;
            div_q         <= CNT_W'(DEFAULT_DIV);
            pending_q     <= CNT_W'(DEFAULT_DIV);
            pending_vld_q <= 1'b0;
            tick_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            tick_q <= run & (cnt_p0 == half);
            ack_q  <= apply;
            if (run) begin
                cnt_p0 <= at_end ? '0 : cnt_p0 + CNT_W'(1);
            end
            if (apply) begin
                div_q         <= pending_q;
                pending_vld_q <= 1'b0;
            end
            // A new capture wins over the clear of an older one applied now.
            if (div_load) begin
                pending_q     <= clamp_ratio(div_ratio_in);
                pending_vld_q <= 1'b1;
            end
        end
    end

    // Stage p1: base clock and per-channel delay line
    always_ff @(posedge clock) begin
        if (reset) begin
            chan_p1 <= '0;
        end else if (run) begin
            chan_p1[0] <= (cnt_p0 >= half);
            for (int i = 1; i < NUM_CH; i++) begin
                chan_p1[i] <= chan_p1[i-1];
            end
        end
    end

    assign clk_out      = chan_p1 ^ INV_MASK;
    assign tick         = tick_q;
    assign div_active   = div_q;
    assign load_pending = pending_vld_q;
    assign load_ack     = ack_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//   Directed scenarios followed by randomized traffic, compared every cycle
//   against a behavioural model of the divider.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int         NUM_CH      = 4;
    localparam int         CNT_W       = 8;
    localparam int         DEFAULT_DIV = 4;
    localparam logic [3:0] INV_MASK    = 4'b1010;

    logic              clock = 1'b0;
    logic              reset;
    logic              run;
    logic              div_load;
    logic [CNT_W-1:0]  div_ratio_in;
    logic [NUM_CH-1:0] clk_out;
    logic              tick;
    logic [CNT_W-1:0]  div_active;
    logic              load_pending;
    logic              load_ack;

    always #5 clock = ~clock;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .INV_MASK    (INV_MASK)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .div_load     (div_load),
        .div_ratio_in (div_ratio_in),
        .clk_out      (clk_out),
        .tick         (tick),
        .div_active   (div_active),
        .load_pending (load_pending),
        .load_ack     (load_ack)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: position in the period, ratio in effect, pending
    // request, and the history of base-clock levels over active cycles.
    int m_cnt  = 0;
    int m_div  = DEFAULT_DIV;
    int m_pend = DEFAULT_DIV;
    bit m_lp   = 0;
    bit m_tick = 0;
    bit m_ack  = 0;
    bit hist[$];

    // Channel i shows the base level from i active cycles before the newest.
    function automatic logic [3:0] model_clk();
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hist.size() > i) v[i] = hist[hist.size() - 1 - i];
        end
        return v ^ INV_MASK;
    endfunction

    task automatic model_edge();
        bit last;
        bit app;
        if (reset) begin
            m_cnt  = 0;
            m_div  = DEFAULT_DIV;
            m_pend = DEFAULT_DIV;
            m_lp   = 0;
            m_tick = 0;
            m_ack  = 0;
            hist.delete();
        end else begin
            last   = (m_cnt == m_div - 1);
            app    = run && m_lp && last;
            m_tick = run && (m_cnt == m_div / 2);
            m_ack  = app;
            if (run) begin
                hist.push_back(m_cnt >= m_div / 2);
                if (hist.size() > NUM_CH) void'(hist.pop_front());
                m_cnt = last ? 0 : m_cnt + 1;
            end
            if (app) begin
                m_div = m_pend;
                m_lp  = 0;
            end
            if (div_load) begin
                m_pend = (div_ratio_in < 2) ? 2 : int'(div_ratio_in);
                m_lp   = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("clk_out",      32'(clk_out),      32'(model_clk()));
        chk("tick",         32'(tick),         32'(m_tick));
        chk("div_active",   32'(div_active),   32'(m_div));
        chk("load_pending", 32'(load_pending), 32'(m_lp));
        chk("load_ack",     32'(load_ack),     32'(m_ack));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_until_cnt(input int target);
        for (int i = 0; i < 40 && m_cnt != target; i++) step();
        if (m_cnt != target) begin
            miscompares++;
            $error("FAIL reach_cnt observed=%0d expected=%0d", m_cnt, target);
        end
    endtask

    initial begin
        int acks;
        reset        = 1'b1;
        run          = 1'b1;
        div_load     = 1'b0;
        div_ratio_in = '0;

        // Reset state
        repeat (3) step();
        chk("rst_clk_out", 32'(clk_out), 32'h0000000A);
        chk("rst_div",     32'(div_active), 32'd4);
        reset = 1'b0;

        // Default ratio 4: base clock reads 0011 repeating
        for (int k = 0; k < 8; k++) begin
            step();
            chk("pat0011", 32'(clk_out[0]), ((k % 4) >= 2) ? 32'd1 : 32'd0);
        end

        // Load ratio 6 at cnt=1
        step();
        div_load     = 1'b1;
        div_ratio_in = 8'd6;
        step();
        div_load = 1'b0;
        chk("lp_after_load", 32'(load_pending), 32'd1);
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (load_ack) acks++;
        end
        chk("ack_once", 32'(acks), 32'd1);
        chk("div6",     32'(div_active), 32'd6);

        // Ratio 0 then 1: last write wins, clamped to 2
        div_load     = 1'b1;
        div_ratio_in = 8'd0;
        step();
        div_ratio_in = 8'd1;
        step();
        div_load = 1'b0;
        repeat (20) step();
        chk("div2", 32'(div_active), 32'd2);

        // Back to 4, then freeze at cnt=2 for 5 cycles
        div_load     = 1'b1;
        div_ratio_in = 8'd4;
        step();
        div_load = 1'b0;
        repeat (6) step();
        run_until_cnt(2);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("frz_tick", 32'(tick), 32'd0);
        end
        run = 1'b1;
        repeat (10) step();

        // Load coincident with the wrap cycle
        run_until_cnt(m_div - 1);
        div_load     = 1'b1;
        div_ratio_in = 8'd6;
        step();
        div_load = 1'b0;
        chk("wrap_no_apply", 32'(div_active),   32'd4);
        chk("wrap_lp",       32'(load_pending), 32'd1);
        repeat (14) step();
        chk("wrap_div6", 32'(div_active), 32'd6);

        // Reset with a load pending
        div_load     = 1'b1;
        div_ratio_in = 8'd3;
        step();
        div_load = 1'b0;
        reset    = 1'b1;
        step();
        chk("rst_lp",      32'(load_pending), 32'd0);
        chk("rst_div4",    32'(div_active),   32'd4);
        chk("rst_clk_inv", 32'(clk_out),      32'h0000000A);
        reset = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            reset        = ($urandom_range(0, 99) == 0);
            run          = ($urandom_range(0, 9) != 0);
            div_load     = ($urandom_range(0, 7) == 0);
            div_ratio_in = 8'($urandom_range(0, 9));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
